pattern_scheduler: RTL

Controls the LED pattern ROM that the sequencer currently drives directly. Debounces the sequence-select push-buttons and walks the step address of the selected sequence once per throttle tick. Fetches each step word through the ROM read port, handles the ROM read latency and the end-of-sequence flag, and registers the LEDR output. Sits between throttle (tick source), the pattern ROM and seg_disp (seq_num, rom_addr).

---
 rtl/pattern_scheduler.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scheduler
// Purpose  : Walks the LED pattern ROM for the selected sequence. Debounces
//            the sequence-select buttons, fetches one step word per throttle
//            tick, hides the ROM read latency and honours the last-step flag.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_50     in   system clock (50 MHz)
//   reset      in   asynchronous active-low reset
//   tick       in   one-cycle step strobe from the throttle
//   run_en     in   1 = advance on tick, 0 = freeze on the current step
//   pb_seq_up  in   raw active-low push-button, sequence + 1
//   pb_seq_dn  in   raw active-low push-button, sequence - 1
//   rom_q      in   ROM word: [LED_W] last-step flag, [LED_W-1:0] pattern
//   rom_rd     out  one-cycle read strobe per fetch
//   rom_addr   out  {seq_num, step_num}, stable from one fetch to the next
//   seq_num    out  selected sequence
//   step_num   out  current step
//   LEDR       out  registered pattern of the current step
//   busy       out  high while a fetch is outstanding (FETCH or WAIT)
// ============================================================================
module pattern_scheduler #(
  parameter int SEQ_W           = 6,
  parameter int STEP_W          = 4,
  parameter int LED_W           = 10,
  parameter int ROM_LAT         = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run_en,
  input  logic                    pb_seq_up,
  input  logic                    pb_seq_dn,
  input  logic [LED_W:0]          rom_q,
  output logic                    rom_rd,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [STEP_W-1:0]       step_num,
  output logic [LED_W-1:0]        LEDR,
  output logic                    busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE   = c_DB_W'(1);
  localparam logic [1:0]        c_LAT_LAST = 2'(ROM_LAT - 1);
  localparam logic [SEQ_W-1:0]  c_SEQ_ONE  = SEQ_W'(1);
  localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] c_STEP_MAX = {STEP_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: index 0 = up, index 1 = down.
  // Each button is synchronised, then must present DEBOUNCE_CYCLES
  // consecutive samples of the new level before the level is accepted.
  // Only an accepted release->press edge produces a one-cycle event.
  // --------------------------------------------------------------------------
  logic [1:0] w_pb_raw;
  logic [1:0] w_press;

  assign w_pb_raw = {pb_seq_dn, pb_seq_up};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_btn
      logic              r_sync0;
      logic              r_sync1;
      logic              r_level;
      logic              r_evt;
      logic [c_DB_W-1:0] r_cnt;

      always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
          // Buttons are active-low: the released level is 1.
          r_sync0 <= 1'b1;
          r_sync1 <= 1'b1;
          r_level <= 1'b1;
          r_evt   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync0 <= w_pb_raw[g];
          r_sync1 <= r_sync0;
          r_evt   <= 1'b0;
          if (r_sync1 == r_level) begin
            // Any sample matching the accepted level restarts the run.
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_level <= r_sync1;
            r_cnt   <= '0;
            r_evt   <= ~r_sync1;
          end else begin
            r_cnt <= r_cnt + c_DB_ONE;
          end
        end
      end

      assign w_press[g] = r_evt;
    end
  endgenerate

  // Simultaneous up and down events cancel each other out.
  logic w_up;
  logic w_dn;
  logic w_seq_chg;

  assign w_up      = w_press[0] & ~w_press[1];
  assign w_dn      = w_press[1] & ~w_press[0];
  assign w_seq_chg = w_up | w_dn;

  // --------------------------------------------------------------------------
  // Fetch state machine
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_wcnt;
  logic              r_pend;
  logic              r_last;
  logic [SEQ_W-1:0]  r_seq;
  logic [STEP_W-1:0] r_step;
  logic [LED_W-1:0]  r_led;
  logic              w_capture;
  logic              w_advance;
  logic              w_rom_rd;
  logic              w_busy;

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_rom_rd    = 1'b0;
    w_busy      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_rom_rd    = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_wcnt == c_LAT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_pend || (tick && run_en)) begin
          w_advance   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new sequence selection overrides everything: any in-flight word is
    // dropped and step 0 of the new sequence is fetched next.
    if (w_seq_chg) begin
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_state_nxt = S_FETCH;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      r_wcnt <= '0;
      r_pend <= 1'b0;
      r_last <= 1'b0;
      r_seq  <= '0;
      r_step <= '0;
      r_led  <= '0;
    end else begin
      // Latency counter runs only while staying in WAIT, so it is always
      // zero on entry to WAIT.
      if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
        r_wcnt <= r_wcnt + 2'd1;
      end else begin
        r_wcnt <= '0;
      end

      // One-deep memory for a tick that lands while a fetch is in flight.
      if (w_seq_chg || w_advance) begin
        r_pend <= 1'b0;
      end else if (w_busy && tick && run_en) begin
        r_pend <= 1'b1;
      end

      if (w_capture) begin
        r_led  <= rom_q[LED_W-1:0];
        r_last <= rom_q[LED_W];
      end

      if (w_seq_chg) begin
        r_seq  <= w_up ? (r_seq + c_SEQ_ONE) : (r_seq - c_SEQ_ONE);
        r_step <= '0;
      end else if (w_advance) begin
        if (r_last || (r_step == c_STEP_MAX)) begin
          r_step <= '0;
        end else begin
          r_step <= r_step + c_STEP_ONE;
        end
      end
    end
  end

  // seq/step only change on the transition into FETCH, so the concatenation
  // is already held stable for the whole fetch and the HOLD that follows.
  assign rom_addr = {r_seq, r_step};
  assign rom_rd   = w_rom_rd;
  assign busy     = w_busy;
  assign seq_num  = r_seq;
  assign step_num = r_step;
  assign LEDR     = r_led;

endmodule
`default_nettype wire
